dac_stream_arbiter: RTL and testbench
=====================================

// Module: dac_stream_arbiter
// PURPOSE
// - Shares one AD56x3 DAC driver Avalon-ST sink between NUM_SRC Avalon-ST sample sources (saw generators, host path).
// - Channel A+B words travel as an atomic pair: once a source's A word is accepted, only that source is served until its B word passes.
// - Sources with valid gated by rdy are supported: the idle arbiter offers rdy to one candidate per cycle, round-robin.
// PARAMETERS
// - NUM_SRC     2    number of sources, >= 2; IW = $clog2(NUM_SRC)
// - DATA_WIDTH  14   sample width
// - TIMEOUT     255  max cycles LOCK may wait for B before forced release; 0 = never release
// PORTS
// - clk          in   1                  clock
// - reset        in   1                  asynchronous, active-high
// - snkValid     in   NUM_SRC            per-source valid
// - snkChannel   in   NUM_SRC            per-source channel, 0 = A, 1 = B
// - snkData      in   NUM_SRC*DATA_WIDTH source i at [i*DATA_WIDTH +: DATA_WIDTH]
// - snkRdy       out  NUM_SRC            per-source ready
// - srcValid     out  1                  to DAC driver
// - srcChannel   out  1                  to DAC driver
// - srcData      out  DATA_WIDTH         to DAC driver
// - srcRdy       in   1                  from DAC driver
// - grant        out  NUM_SRC            one-hot LOCK owner, 0 in IDLE (registered)
// - errPair      out  1                  1-cycle pulse: orphan B in IDLE, or repeated A in LOCK
// - errTimeout   out  1                  1-cycle pulse: LOCK released by timeout
// BEHAVIOUR
// - Selected index sel = ptr in IDLE, owner in LOCK. ptr, owner, state, tmr are registers.
// - Datapath is combinational, zero latency:
//   srcValid = snkValid[sel], srcChannel = snkChannel[sel], srcData = slice sel.
// - snkRdy[sel] = srcRdy; all other snkRdy bits = 0. No rdy depends on any valid.
// - xfer = snkValid[sel] & snkRdy[sel].
// - Reset: state IDLE, ptr 0, owner 0, tmr 0, grant 0, errPair/errTimeout 0.
//   snkRdy[0] follows srcRdy immediately after reset; srcValid follows snkValid[0].
// - IDLE:
//   - no xfer: ptr <= (ptr+1) mod NUM_SRC.
//   - xfer, channel 0: owner <= ptr, grant[ptr] <= 1, tmr <= 0, goto LOCK.
//   - xfer, channel 1: word forwarded (never dropped), errPair pulse, ptr <= ptr+1, stay IDLE.
// - LOCK:
//   - xfer, channel 1: release, grant <= 0, ptr <= owner+1 mod NUM_SRC, goto IDLE.
//   - xfer, channel 0: forwarded, errPair pulse, tmr <= 0, stay LOCK.
//   - no xfer: tmr <= tmr+1. If TIMEOUT != 0 and tmr == TIMEOUT-1, release as for B, plus errTimeout pulse.
//   - tmr is $clog2(TIMEOUT+1) bits and saturates when TIMEOUT = 0.
// - Back-to-back pair (A then B next cycle, srcRdy held 1) passes in 2 cycles; the next source is offered rdy on cycle 3.
// - Fairness: after a release, the releasing source gets lowest priority.
//   A waiting source is offered rdy within NUM_SRC idle cycles.
// - srcRdy low: no xfer; the IDLE ptr still rotates; LOCK tmr still counts.
//   Timeout therefore also covers a stalled DAC driver.
// - Reset mid-pair: immediate IDLE, ptr 0. Any half-sent pair is abandoned; downstream resyncs on the next A.
// - Error pulses are registered: asserted the cycle after the offending xfer, for 1 cycle.
// TESTING
// - Reset, NUM_SRC=2, srcRdy=1, idle sources -> snkRdy alternates 01,10,01; grant=0; no errors.
// - Src0 A=0x0010, next cycle B=0x3FF0 -> srcData 0x0010 (ch0), then 0x3FF0 (ch1); grant=01 for 1 cycle; ptr=1 after.
// - Both sources gated by rdy, continuously pending -> pairs alternate src0, src1, src0; no A/B interleaving across sources.
// - Src1 sends A then stalls, TIMEOUT=8 -> errTimeout pulses exactly 8 cycles after the A xfer; grant=0; src0 served next.
// - Src0 sends B=0x0123 in IDLE -> forwarded on srcData; errPair pulse; no lock. Src0 A,A,B -> one errPair, lock held.
// - srcRdy=0 during LOCK for 3 cycles, then 1 -> no xfer; pending B passes the first cycle srcRdy=1; reset mid-LOCK -> grant=0 next edge.

Source files
------------

// File: rtl/dac_stream_if.sv
// Avalon-ST bundle between NUM_SRC sample sources, the arbiter and the DAC driver sink.
// slave = arbiter view, master = environment view (sources plus driver).
interface dac_stream_if #(
    parameter int NUM_SRC    = 2,
    parameter int DATA_WIDTH = 14
);
    logic [NUM_SRC-1:0]            snkValid;
    logic [NUM_SRC-1:0]            snkChannel;
    logic [NUM_SRC*DATA_WIDTH-1:0] snkData;
    logic [NUM_SRC-1:0]            snkRdy;
    logic                          srcValid;
    logic                          srcChannel;
    logic [DATA_WIDTH-1:0]         srcData;
    logic                          srcRdy;

    modport slave (
        input  snkValid, snkChannel, snkData, srcRdy,
        output snkRdy, srcValid, srcChannel, srcData
    );

    modport master (
        output snkValid, snkChannel, snkData, srcRdy,
        input  snkRdy, srcValid, srcChannel, srcData
    );
endinterface

// File: rtl/dac_stream_arbiter.sv
// Round-robin arbiter sharing one AD56x3 DAC driver sink between NUM_SRC sources,
// keeping each source's A/B word pair atomic, with a LOCK timeout for lost B words.
module dac_stream_arb_lane #(
    parameter int IW  = 1,
    parameter int IDX = 0
) (
    input  logic [IW-1:0] sel,
    input  logic          src_rdy,
    output logic          rdy
);
    // Ready never looks at any valid, so rdy-gated sources cannot deadlock.
    assign rdy = src_rdy & (sel == IW'(IDX));
endmodule

module dac_stream_arbiter #(
    parameter int NUM_SRC    = 2,
    parameter int DATA_WIDTH = 14,
    parameter int TIMEOUT    = 255
) (
    input  logic               clk,
    input  logic               reset,
    dac_stream_if.slave        bus,
    output logic [NUM_SRC-1:0] grant,
    output logic               errPair,
    output logic               errTimeout
);
    localparam int IW = $clog2(NUM_SRC);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMAX = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

    typedef enum logic {IDLE, LOCK} state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [IW-1:0]      owner_q, owner_d;
    logic [TW-1:0]      tmr_q, tmr_d;
    logic [NUM_SRC-1:0] grant_d;
    logic               err_pair_d, err_to_d;
    logic [IW-1:0]      sel;
    logic [NUM_SRC-1:0] rdy_vec;
    logic               xfer;

    function automatic logic [IW-1:0] inc(input logic [IW-1:0] p);
        return (p == IW'(NUM_SRC - 1)) ? '0 : p + 1'b1;
    endfunction

    assign sel = (state_q == LOCK) ? owner_q : ptr_q;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_lane
        dac_stream_arb_lane #(.IW(IW), .IDX(i)) u_lane (
            .sel     (sel),
            .src_rdy (bus.srcRdy),
            .rdy     (rdy_vec[i])
        );
    end

    assign bus.snkRdy     = rdy_vec;
    assign bus.srcValid   = bus.snkValid[sel];
    assign bus.srcChannel = bus.snkChannel[sel];
    assign bus.srcData    = bus.snkData[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
    assign xfer           = bus.srcValid & bus.srcRdy;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        tmr_d      = tmr_q;
        grant_d    = grant;
        err_pair_d = 1'b0;
        err_to_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!xfer) begin
                    ptr_d = inc(ptr_q);
                end else if (!bus.srcChannel) begin
                    owner_d = ptr_q;
                    grant_d = NUM_SRC'(1) << ptr_q;
                    tmr_d   = '0;
                    state_d = LOCK;
                end else begin
                    // Orphan B is still forwarded; only flagged.
                    err_pair_d = 1'b1;
                    ptr_d      = inc(ptr_q);
                end
            end
            LOCK: begin
                if (xfer && bus.srcChannel) begin
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = inc(owner_q);
                end else if (xfer) begin
                    err_pair_d = 1'b1;
                    tmr_d      = '0;
                end else if (TIMEOUT != 0 && tmr_q == TMAX) begin
                    // Covers both a source that never sends B and a stalled driver.
                    state_d  = IDLE;
                    grant_d  = '0;
                    ptr_d    = inc(owner_q);
                    err_to_d = 1'b1;
                end else if (tmr_q != '1) begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            owner_q    <= '0;
            tmr_q      <= '0;
            grant      <= '0;
            errPair    <= 1'b0;
            errTimeout <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            tmr_q      <= tmr_d;
            grant      <= grant_d;
            errPair    <= err_pair_d;
            errTimeout <= err_to_d;
        end
    end
endmodule

// File: tb/tb_dac_stream_arbiter.sv
// Directed bench for dac_stream_arbiter: vector table for single-cycle behaviour,
// hand sequences for timeout, driver stall, reset mid-pair and alternating pairs.
module tb_dac_stream_arbiter;
    localparam int NS = 2;
    localparam int DW = 14;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NS-1:0] grant;
    logic          errPair, errTimeout;
    int            n_cmp = 0;
    int            n_err = 0;

    dac_stream_if #(.NUM_SRC(NS), .DATA_WIDTH(DW)) bus ();

    dac_stream_arbiter #(.NUM_SRC(NS), .DATA_WIDTH(DW), .TIMEOUT(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus.slave),
        .grant      (grant),
        .errPair    (errPair),
        .errTimeout (errTimeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  v, ch;
        logic [13:0] d0, d1;
        logic        rdy;
        logic [1:0]  e_rdy;
        logic        e_val, e_ch;
        logic [13:0] e_data;
        logic [1:0]  e_grant;
        logic        e_ep, e_et;
    } vec_t;

    vec_t vt[17];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] ch,
                         input logic [13:0] d0, input logic [13:0] d1, input logic rdy);
        bus.snkValid   = v;
        bus.snkChannel = ch;
        bus.snkData    = {d1, d0};
        bus.srcRdy     = rdy;
    endtask

    logic [1:0]  phase [NS];
    int          npair [NS];
    int          exp_src [6] = '{0, 0, 1, 1, 0, 0};
    int          exp_ch  [6] = '{0, 1, 0, 1, 0, 1};
    int          exp_dat [6] = '{'h000, 'h001, 'h100, 'h101, 'h002, 'h003};
    int          nx, seen, got;
    logic [13:0] rr_d [NS];

    initial begin
        //        v      ch     d0        d1        rdy   e_rdy  val   ch    data      grant  ep    et
        vt[0]  = '{2'b00, 2'b00, 14'h0,    14'h0,    1'b1, 2'b01, 1'b0, 1'b0, 14'h0,    2'b00, 1'b0, 1'b0};
        vt[1]  = '{2'b00, 2'b00, 14'h0,    14'h0,    1'b1, 2'b10, 1'b0, 1'b0, 14'h0,    2'b00, 1'b0, 1'b0};
        vt[2]  = '{2'b00, 2'b00, 14'h0,    14'h0,    1'b1, 2'b01, 1'b0, 1'b0, 14'h0,    2'b00, 1'b0, 1'b0};
        vt[3]  = '{2'b00, 2'b00, 14'h0,    14'h0,    1'b1, 2'b10, 1'b0, 1'b0, 14'h0,    2'b00, 1'b0, 1'b0};
        vt[4]  = '{2'b01, 2'b00, 14'h0010, 14'h0,    1'b1, 2'b01, 1'b1, 1'b0, 14'h0010, 2'b00, 1'b0, 1'b0};
        vt[5]  = '{2'b01, 2'b01, 14'h3FF0, 14'h0,    1'b1, 2'b01, 1'b1, 1'b1, 14'h3FF0, 2'b01, 1'b0, 1'b0};
        vt[6]  = '{2'b00, 2'b00, 14'h0,    14'h0,    1'b1, 2'b10, 1'b0, 1'b0, 14'h0,    2'b00, 1'b0, 1'b0};
        vt[7]  = '{2'b01, 2'b01, 14'h0123, 14'h0,    1'b1, 2'b01, 1'b1, 1'b1, 14'h0123, 2'b00, 1'b0, 1'b0};
        vt[8]  = '{2'b00, 2'b00, 14'h0,    14'h0,    1'b1, 2'b10, 1'b0, 1'b0, 14'h0,    2'b00, 1'b1, 1'b0};
        vt[9]  = '{2'b00, 2'b00, 14'h0,    14'h0,    1'b1, 2'b01, 1'b0, 1'b0, 14'h0,    2'b00, 1'b0, 1'b0};
        vt[10] = '{2'b10, 2'b00, 14'h0,    14'h0555, 1'b1, 2'b10, 1'b1, 1'b0, 14'h0555, 2'b00, 1'b0, 1'b0};
        vt[11] = '{2'b10, 2'b00, 14'h0,    14'h0556, 1'b1, 2'b10, 1'b1, 1'b0, 14'h0556, 2'b10, 1'b0, 1'b0};
        vt[12] = '{2'b10, 2'b10, 14'h0,    14'h0AAA, 1'b1, 2'b10, 1'b1, 1'b1, 14'h0AAA, 2'b10, 1'b1, 1'b0};
        vt[13] = '{2'b00, 2'b00, 14'h0,    14'h0,    1'b1, 2'b01, 1'b0, 1'b0, 14'h0,    2'b00, 1'b0, 1'b0};
        vt[14] = '{2'b11, 2'b00, 14'h0011, 14'h0022, 1'b0, 2'b00, 1'b1, 1'b0, 14'h0022, 2'b00, 1'b0, 1'b0};
        vt[15] = '{2'b11, 2'b00, 14'h0011, 14'h0022, 1'b0, 2'b00, 1'b1, 1'b0, 14'h0011, 2'b00, 1'b0, 1'b0};
        vt[16] = '{2'b00, 2'b00, 14'h0,    14'h0,    1'b1, 2'b10, 1'b0, 1'b0, 14'h0,    2'b00, 1'b0, 1'b0};

        drive(2'b00, 2'b00, 14'h0, 14'h0, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_grant", grant, 0);
        chk("rst_snkRdy", bus.snkRdy, 2'b01);
        chk("rst_errPair", errPair, 0);
        chk("rst_errTimeout", errTimeout, 0);
        reset = 1'b0;

        for (int i = 0; i < 17; i++) begin
            drive(vt[i].v, vt[i].ch, vt[i].d0, vt[i].d1, vt[i].rdy);
            #1;
            chk($sformatf("v%0d_snkRdy", i), bus.snkRdy, vt[i].e_rdy);
            chk($sformatf("v%0d_srcValid", i), bus.srcValid, vt[i].e_val);
            chk($sformatf("v%0d_srcChannel", i), bus.srcChannel, vt[i].e_ch);
            chk($sformatf("v%0d_srcData", i), bus.srcData, vt[i].e_data);
            chk($sformatf("v%0d_grant", i), grant, vt[i].e_grant);
            chk($sformatf("v%0d_errPair", i), errPair, vt[i].e_ep);
            chk($sformatf("v%0d_errTimeout", i), errTimeout, vt[i].e_et);
            @(negedge clk);
        end

        // Src1 sends A then goes silent; src0 waits with its own A.
        drive(2'b10, 2'b00, 14'h0, 14'h0777, 1'b1);
        got = 0;
        for (int k = 0; k < 4; k++) begin
            #1;
            if (bus.snkRdy[1]) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        chk("to_a_accept", got, 1);
        @(negedge clk);
        drive(2'b01, 2'b00, 14'h0100, 14'h0, 1'b1);
        seen = -1;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (k == 0) begin
                chk("to_lock_grant", grant, 2'b10);
                chk("to_lock_snkRdy", bus.snkRdy, 2'b10);
            end
            if (errTimeout) begin
                seen = k;
                break;
            end
            @(negedge clk);
        end
        chk("to_delay", seen, 8);
        chk("to_rel_grant", grant, 0);
        chk("to_rel_snkRdy", bus.snkRdy, 2'b01);
        chk("to_src0_data", bus.srcData, 'h0100);
        @(negedge clk);
        #1;
        chk("to_src0_grant", grant, 2'b01);
        chk("to_pulse_len", errTimeout, 0);
        drive(2'b01, 2'b01, 14'h0101, 14'h0, 1'b1);
        #1;
        chk("to_src0_b", bus.srcData, 'h0101);
        @(negedge clk);
        #1;
        chk("to_src0_rel", grant, 0);

        // Driver stalls for 3 cycles while src1 holds its B word.
        drive(2'b10, 2'b00, 14'h0, 14'h0200, 1'b1);
        #1;
        chk("st_a_snkRdy", bus.snkRdy, 2'b10);
        @(negedge clk);
        drive(2'b10, 2'b10, 14'h0, 14'h0201, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("st%0d_snkRdy", k), bus.snkRdy, 2'b00);
            chk($sformatf("st%0d_grant", k), grant, 2'b10);
            @(negedge clk);
        end
        bus.srcRdy = 1'b1;
        #1;
        chk("st_b_snkRdy", bus.snkRdy, 2'b10);
        chk("st_b_data", bus.srcData, 'h0201);
        chk("st_b_ch", bus.srcChannel, 1);
        @(negedge clk);
        #1;
        chk("st_rel_grant", grant, 0);

        // Reset in the middle of a src0 pair.
        drive(2'b01, 2'b00, 14'h0300, 14'h0, 1'b1);
        @(negedge clk);
        #1;
        chk("rm_lock_grant", grant, 2'b01);
        drive(2'b00, 2'b00, 14'h0, 14'h0, 1'b1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rm_grant", grant, 0);
        chk("rm_snkRdy", bus.snkRdy, 2'b01);
        @(negedge clk);
        reset = 1'b0;

        // Both sources always pending, rdy-gated: pairs must alternate whole.
        for (int i = 0; i < NS; i++) begin
            phase[i] = 2'd0;
            npair[i] = 0;
        end
        nx = 0;
        for (int cyc = 0; cyc < 30 && nx < 6; cyc++) begin
            for (int i = 0; i < NS; i++) rr_d[i] = 14'(i * 'h100 + npair[i] * 2 + int'(phase[i]));
            drive(2'b11, {phase[1][0], phase[0][0]}, rr_d[0], rr_d[1], 1'b1);
            #1;
            for (int i = 0; i < NS; i++) begin
                if (bus.snkRdy[i] && nx < 6) begin
                    chk($sformatf("rr%0d_src", nx), i, exp_src[nx]);
                    chk($sformatf("rr%0d_ch", nx), bus.srcChannel, exp_ch[nx]);
                    chk($sformatf("rr%0d_data", nx), bus.srcData, exp_dat[nx]);
                    if (phase[i] == 2'd1) begin
                        phase[i] = 2'd0;
                        npair[i]++;
                    end else begin
                        phase[i] = 2'd1;
                    end
                    nx++;
                end
            end
            @(negedge clk);
        end
        chk("rr_count", nx, 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
